// File: rtl/add_pipe_cla.sv
// ============================================================================
// Module   : add_pipe_cla
// Purpose  : Pipelined carry-lookahead adder/subtractor. The operand is cut
//            into STAGES = WIDTH/GROUP groups; stage k resolves group k with
//            a full in-group lookahead and registers the group carry forward.
//            Unprocessed upper operand bits travel down the pipe skewed, and
//            completed lower sum groups accumulate alongside them.
//            A global advance enable gives full back-pressure: when the
//            output is held, every stage holds.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready, a, b, cin, sub   - operand beat
//            out_valid/out_ready, sum, cout, ovf - result beat
//            sub=0: sum = a + b + cin ; sub=1: sum = a - b - cin
//            cout in sub mode is the inverted borrow (1 = no borrow).
// Options  : `define ADD_PIPE_SAT_EN to saturate sum on signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module add_pipe_cla #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0) begin : g_param_check
    $error("add_pipe_cla: WIDTH must be a multiple of GROUP");
  end

  // One shared enable: the pipe moves only when the output slot is empty
  // or being drained, so every stage shifts (or holds) in lock-step.
  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Group adder with prefix lookahead: each carry is formed from the
  // accumulated group generate/propagate and the group carry-in, so no
  // carry depends on a lower in-group carry signal. Returns {cout, sum}.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] x,
                                               input logic [GROUP-1:0] y,
                                               input logic             ci);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             gg;
    logic             pp;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    gg   = 1'b0;
    pp   = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      gg       = g[i] | (p[i] & gg);
      pp       = pp & p[i];
      c[i+1]   = gg | (pp & ci);
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - k*GROUP;   // operand bits still unprocessed
    localparam int SW  = (k+1)*GROUP;       // sum bits complete after stage

    logic [REM-1:0] a_in;
    logic [REM-1:0] b_in;
    logic           c_in;
    logic           v_in;
    logic [GROUP:0] res;
    logic [SW-1:0]  s_raw;
    logic [SW-1:0]  s_next;
    logic           v_q;
    logic           c_q;
    logic [SW-1:0]  s_q;

    if (k == 0) begin : g_head
      // Subtract as A + ~B + !cin.
      assign a_in  = a;
      assign b_in  = sub ? ~b : b;
      assign c_in  = cin ^ sub;
      assign v_in  = in_valid;
      assign s_raw = res[GROUP-1:0];
    end else begin : g_body
      assign a_in  = g_stage[k-1].g_fwd.a_q;
      assign b_in  = g_stage[k-1].g_fwd.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign s_raw = {res[GROUP-1:0], g_stage[k-1].s_q};
    end

    assign res = cla_group(a_in[GROUP-1:0], b_in[GROUP-1:0], c_in);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= res[GROUP];
        s_q <= s_next;
      end
    end

    if (k < STAGES-1) begin : g_fwd
      // Upper groups not yet added, shifted down to start at bit 0.
      logic [REM-GROUP-1:0] a_q;
      logic [REM-GROUP-1:0] b_q;
      assign s_next = s_raw;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[REM-1:GROUP];
          b_q <= b_in[REM-1:GROUP];
        end
      end
    end else begin : g_last
      logic ovf_d;
      logic ovf_q;
      // Carry-into-MSB XOR carry-out-of-MSB, written in its equivalent
      // operand-sign form: like-signed operands producing an unlike sign.
      // a_in[GROUP-1] is the original MSB of A, b_in[GROUP-1] that of B'.
      assign ovf_d = (a_in[GROUP-1] == b_in[GROUP-1]) &&
                     (res[GROUP-1] != a_in[GROUP-1]);
`ifdef ADD_PIPE_SAT_EN
      assign s_next = !ovf_d         ? s_raw :
                      a_in[GROUP-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                       {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign s_next = s_raw;
`endif
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

`default_nettype wire
